// File: rtl/axis_frame_stats.sv
// Passive AXI-stream frame statistics: per-channel frame/byte/error counters and
// first-word capture, exposed over an AXI-lite slave, with an LED tap of one channel.

module axis_frame_stats_ch #(
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc,
  input  logic [31:0]           tdata,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  input  logic                  tlast,
  input  logic                  tuser,
  output logic [CNT_WIDTH-1:0]  frames,
  output logic [CNT_WIDTH-1:0]  bytes,
  output logic [CNT_WIDTH-1:0]  errors,
  output logic [31:0]           first_word
);
  localparam int PW = $clog2(KEEP_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_FRAME} state_t;
  state_t state, state_nxt;

  logic              cap_first;
  logic [PW-1:0]     keep_cnt;
  logic [CNT_WIDTH:0] byte_sum;

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        IDLE:     if (!tlast) state_nxt = IN_FRAME;
        IN_FRAME: if (tlast)  state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cap_first = acc && (state == IDLE);
  end

  always_comb begin
    keep_cnt = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) keep_cnt = keep_cnt + PW'(tkeep[k]);
  end

  // carry bit of the widened sum flags byte-counter overflow
  assign byte_sum = {1'b0, bytes} + {{(CNT_WIDTH + 1 - PW){1'b0}}, keep_cnt};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      frames     <= '0;
      bytes      <= '0;
      errors     <= '0;
      first_word <= '0;
    end else if (acc) begin
      if (cap_first) first_word <= tdata;
      bytes <= byte_sum[CNT_WIDTH] ? CNT_MAX : byte_sum[CNT_WIDTH-1:0];
      if (tlast && frames != CNT_MAX)          frames <= frames + CNT_WIDTH'(1);
      if (tlast && tuser && errors != CNT_MAX) errors <= errors + CNT_WIDTH'(1);
    end
  end
endmodule

module axis_frame_stats #(
  parameter int N_CH            = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int CNT_WIDTH       = 32,
  parameter int AXIL_ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*DATA_WIDTH-1:0]   mon_tdata,
  input  logic [N_CH*KEEP_WIDTH-1:0]   mon_tkeep,
  input  logic [N_CH-1:0]              mon_tvalid,
  input  logic [N_CH-1:0]              mon_tready,
  input  logic [N_CH-1:0]              mon_tlast,
  input  logic [N_CH-1:0]              mon_tuser,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [31:0]                  s_axil_wdata,
  input  logic [3:0]                   s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [31:0]                  s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [7:0]                   led
);
  localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_CLEAR   = AXIL_ADDR_WIDTH'(12'h100);
  localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_LED_SEL = AXIL_ADDR_WIDTH'(12'h104);

  logic [N_CH-1:0]                acc, clr;
  logic [N_CH-1:0][CNT_WIDTH-1:0] frames, bytes, errors;
  logic [N_CH-1:0][31:0]          first_word;

  logic        wr_hs, ar_hs, wr_clr, wr_sel;
  logic [2:0]  led_sel;
  logic [7:0]  led_nxt;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign unused_ok = ^{mon_tdata, s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata};

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign acc[i] = mon_tvalid[i] & mon_tready[i];
      assign clr[i] = wr_clr & s_axil_wdata[i];
      axis_frame_stats_ch #(.KEEP_WIDTH(KEEP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr[i]),
        .acc        (acc[i]),
        .tdata      (mon_tdata[i*DATA_WIDTH +: 32]),
        .tkeep      (mon_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]),
        .tlast      (mon_tlast[i]),
        .tuser      (mon_tuser[i]),
        .frames     (frames[i]),
        .bytes      (bytes[i]),
        .errors     (errors[i]),
        .first_word (first_word[i])
      );
    end
  endgenerate

  // address and data are held by the master through the handshake cycle
  assign wr_hs  = s_axil_awready & s_axil_awvalid & s_axil_wvalid;
  assign wr_clr = wr_hs && s_axil_awaddr == ADDR_CLEAR   && s_axil_wstrb[0];
  assign wr_sel = wr_hs && s_axil_awaddr == ADDR_LED_SEL && s_axil_wstrb[0];
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      led_sel        <= '0;
    end else begin
      if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
      if (wr_hs) begin
        s_axil_awready <= 1'b0;
        s_axil_wready  <= 1'b0;
        s_axil_bvalid  <= 1'b1;
      end else if (s_axil_awvalid && s_axil_wvalid && !s_axil_awready && !s_axil_bvalid) begin
        s_axil_awready <= 1'b1;
        s_axil_wready  <= 1'b1;
      end
      if (wr_sel) led_sel <= s_axil_wdata[2:0];
    end
  end

  assign ar_hs = s_axil_arready & s_axil_arvalid;

  always_comb begin
    rd_mux = '0;
    if (s_axil_araddr[AXIL_ADDR_WIDTH-1:8] == '0) begin
      for (int c = 0; c < N_CH; c++) begin
        if (s_axil_araddr[7:4] == 4'(c)) begin
          case (s_axil_araddr[3:2])
            2'd0:    rd_mux = 32'(frames[c]);
            2'd1:    rd_mux = 32'(bytes[c]);
            2'd2:    rd_mux = 32'(errors[c]);
            default: rd_mux = first_word[c];
          endcase
        end
      end
    end
    if (s_axil_araddr == ADDR_LED_SEL) rd_mux = {29'b0, led_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
    end else begin
      if (s_axil_rvalid && s_axil_rready) s_axil_rvalid <= 1'b0;
      if (ar_hs) begin
        s_axil_arready <= 1'b0;
        s_axil_rvalid  <= 1'b1;
        s_axil_rdata   <= rd_mux;
      end else if (s_axil_arvalid && !s_axil_arready && !s_axil_rvalid) begin
        s_axil_arready <= 1'b1;
      end
    end
  end

  // out-of-range selects never match, leaving channel 0
  always_comb begin
    led_nxt = first_word[0][7:0];
    for (int c = 0; c < N_CH; c++) if (led_sel == 3'(c)) led_nxt = first_word[c][7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= led_nxt;
  end
endmodule

// File: tb/tb_axis_frame_stats.sv
// Directed bench for axis_frame_stats: hand-computed expectations checked over AXI-lite.

module tb_axis_frame_stats;
  localparam int N_CH = 4, DW = 64, KW = 8, CW = 16, AW = 16;

  logic clk = 1'b0, rst;
  logic [N_CH*DW-1:0] mon_tdata;
  logic [N_CH*KW-1:0] mon_tkeep;
  logic [N_CH-1:0]    mon_tvalid, mon_tready, mon_tlast, mon_tuser;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [7:0]    led;

  int checks = 0, errors = 0;

  axis_frame_stats #(.N_CH(N_CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW),
                     .AXIL_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tuser(mon_tuser),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int ch, input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u, input logic rdy);
    mon_tdata[ch*DW +: DW] = d;
    mon_tkeep[ch*KW +: KW] = k;
    mon_tlast[ch] = l; mon_tuser[ch] = u;
    mon_tvalid[ch] = 1'b1; mon_tready[ch] = rdy;
    tick();
    mon_tvalid[ch] = 1'b0; mon_tready[ch] = 1'b0;
    mon_tlast[ch] = 1'b0; mon_tuser[ch] = 1'b0;
  endtask

  // with_beat drives a single-beat tlast frame on ch0 in the handshake cycle
  task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit with_beat);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) check("awready_timeout", 32'(awready), 32'd1);
    check("wready_with_awready", 32'(wready), 32'd1);
    if (with_beat) begin
      mon_tdata[0 +: DW] = 64'h0000_0000_9999_9999; mon_tkeep[0 +: KW] = 8'hff;
      mon_tlast[0] = 1'b1; mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1;
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    mon_tvalid[0] = 1'b0; mon_tready[0] = 1'b0; mon_tlast[0] = 1'b0;
    check("bvalid_after_hs", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    tick();
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) check("arready_timeout", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    if (!rvalid) check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mon_tdata = '0; mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0;
    mon_tlast = '0; mon_tuser = '0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0; tick();
    rd_check("rst_ch0_frames", 16'h000, 32'd0);
    rd_check("rst_led_sel", 16'h104, 32'd0);

    // ch0: 3-beat frame, 8+8+4 bytes
    beat(0, 64'h1122_3344_5566_77A5, 8'hff, 1'b0, 1'b0, 1'b1);
    beat(0, 64'h0000_0000_BBBB_BBBB, 8'hff, 1'b0, 1'b0, 1'b1);
    beat(0, 64'h0000_0000_CCCC_CCCC, 8'h0f, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    check("ch0_led", 32'(led), 32'h0000_00A5);
    rd_check("ch0_frames", 16'h000, 32'd1);
    rd_check("ch0_bytes",  16'h004, 32'd20);
    rd_check("ch0_errors", 16'h008, 32'd0);
    rd_check("ch0_first",  16'h00C, 32'h5566_77A5);

    // ch1: single-beat errored frame, then a 2-beat frame proving FSM back in IDLE
    beat(1, 64'h0000_0000_DEAD_BE3C, 8'h01, 1'b1, 1'b1, 1'b1);
    rd_check("ch1_frames_a", 16'h010, 32'd1);
    rd_check("ch1_bytes_a",  16'h014, 32'd1);
    rd_check("ch1_errors_a", 16'h018, 32'd1);
    rd_check("ch1_first_a",  16'h01C, 32'hDEAD_BE3C);
    beat(1, 64'h0000_0000_1111_0077, 8'h03, 1'b0, 1'b0, 1'b1);
    beat(1, 64'h0000_0000_2222_0088, 8'h01, 1'b1, 1'b0, 1'b1);
    rd_check("ch1_frames_b", 16'h010, 32'd2);
    rd_check("ch1_bytes_b",  16'h014, 32'd4);
    rd_check("ch1_errors_b", 16'h018, 32'd1);
    rd_check("ch1_first_b",  16'h01C, 32'h1111_0077);

    // ch2: valid without ready is never counted
    repeat (5) beat(2, 64'h0000_0000_5555_5555, 8'hff, 1'b1, 1'b1, 1'b0);
    rd_check("ch2_frames_stall", 16'h020, 32'd0);
    rd_check("ch2_bytes_stall",  16'h024, 32'd0);
    rd_check("ch2_errors_stall", 16'h028, 32'd0);
    rd_check("ch2_first_stall",  16'h02C, 32'd0);

    // LED_SEL
    axil_write(16'h104, 32'd1, 4'b0001, 1'b0);
    rd_check("led_sel_1", 16'h104, 32'd1);
    tick(); tick();
    check("led_ch1", 32'(led), 32'h0000_0077);
    axil_write(16'h104, 32'd2, 4'b1110, 1'b0);
    rd_check("led_sel_nostrb", 16'h104, 32'd1);
    axil_write(16'h104, 32'd5, 4'b0001, 1'b0);
    rd_check("led_sel_5", 16'h104, 32'd5);
    tick(); tick();
    check("led_oob_ch0", 32'(led), 32'h0000_00A5);
    rd_check("unmapped_200", 16'h200, 32'd0);
    axil_write(16'h200, 32'hFFFF_FFFF, 4'hf, 1'b0);
    rd_check("clear_reads_0", 16'h100, 32'd0);

    // clear ch0 in the same cycle as a ch0 tlast accept
    axil_write(16'h100, 32'h1, 4'b0001, 1'b1);
    rd_check("clr_ch0_frames", 16'h000, 32'd0);
    rd_check("clr_ch0_bytes",  16'h004, 32'd0);
    rd_check("clr_ch0_first",  16'h00C, 32'd0);
    rd_check("clr_ch1_frames", 16'h010, 32'd2);
    rd_check("clr_ch1_bytes",  16'h014, 32'd4);
    check("led_after_clr", 32'(led), 32'd0);

    // reset in mid-frame: next beat is a frame start
    beat(0, 64'h0000_0000_0000_00C1, 8'h0f, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    rd_check("rst2_ch0_first", 16'h00C, 32'd0);
    rd_check("rst2_ch1_frames", 16'h010, 32'd0);
    rd_check("rst2_led_sel", 16'h104, 32'd0);
    beat(0, 64'hFFFF_FFFF_CAFE_00D2, 8'h03, 1'b1, 1'b0, 1'b1);
    rd_check("rst2_ch0_first_b", 16'h00C, 32'hCAFE_00D2);
    rd_check("rst2_ch0_frames",  16'h000, 32'd1);
    rd_check("rst2_ch0_bytes",   16'h004, 32'd2);
    check("rst2_led", 32'(led), 32'h0000_00D2);

    // saturation: ch3 one byte/frame/error per cycle, ch2 eight bytes per cycle
    mon_tdata[3*DW +: DW] = 64'h0; mon_tkeep[3*KW +: KW] = 8'h01;
    mon_tlast[3] = 1; mon_tuser[3] = 1; mon_tvalid[3] = 1; mon_tready[3] = 1;
    mon_tdata[2*DW +: DW] = 64'h0000_0000_1234_5678; mon_tkeep[2*KW +: KW] = 8'hff;
    mon_tlast[2] = 1; mon_tuser[2] = 0; mon_tvalid[2] = 1; mon_tready[2] = 1;
    for (int i = 0; i < 65540; i++) begin
      if (i == 8200) begin mon_tvalid[2] = 0; mon_tready[2] = 0; end
      tick();
    end
    mon_tvalid = '0; mon_tready = '0; mon_tlast = '0; mon_tuser = '0;
    rd_check("sat_ch3_frames", 16'h030, 32'h0000_FFFF);
    rd_check("sat_ch3_bytes",  16'h034, 32'h0000_FFFF);
    rd_check("sat_ch3_errors", 16'h038, 32'h0000_FFFF);
    rd_check("sat_ch2_frames", 16'h020, 32'd8200);
    rd_check("sat_ch2_bytes",  16'h024, 32'h0000_FFFF);
    rd_check("sat_ch2_errors", 16'h028, 32'd0);
    rd_check("sat_ch2_first",  16'h02C, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_frame_stats.md
AXIS_FRAME_STATS -- requirements
Module: axis_frame_stats

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of monitored AXI-stream channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, tdata width per channel (multiple of 32, 32..512).
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width per channel.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, counter width (16..32).
REQ-005 SHALL have parameter AXIL_ADDR_WIDTH, default 16, AXI-lite address width; AXI-lite data width fixed at 32.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset (rst synchronous, active-high; clock clk).
REQ-007 SHALL have ports mon_tdata in N_CH*DATA_WIDTH, mon_tkeep in N_CH*KEEP_WIDTH, mon_tvalid/mon_tready/mon_tlast/mon_tuser in N_CH each; passive taps, channel i in slice i.
REQ-008 SHALL have AXI-lite slave s_axil_aw*/w*/b*/ar*/r* (awaddr, awprot, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready, araddr, arprot, arvalid, arready, rdata 32, rresp 2, rvalid, rready).
REQ-009 SHALL have output led out 8, first byte of last frame started on the selected channel.

Function
REQ-010 SHALL count a beat on channel i only when mon_tvalid[i] & mon_tready[i] (accept); no signal driven toward the stream.
REQ-011 SHALL keep per-channel FSM IDLE/IN_FRAME: IDLE+accept+!tlast -> IN_FRAME; IN_FRAME+accept+tlast -> IDLE; IDLE+accept+tlast (single-beat frame) stays IDLE.
REQ-012 SHALL, on accept in IDLE, register tdata[31:0] of that channel as FIRST_WORD, one cycle latency.
REQ-013 SHALL add popcount(tkeep) of every accepted beat to BYTES counter, any state.
REQ-014 SHALL increment FRAMES on each accepted tlast beat, and ERRORS on each accepted beat with tlast & tuser.
REQ-015 SHALL saturate FRAMES, BYTES, ERRORS at 2^CNT_WIDTH-1; BYTES saturates if sum would overflow.
REQ-016 SHALL map registers at channel base i*0x10: +0x0 FRAMES, +0x4 BYTES, +0x8 ERRORS, +0xC FIRST_WORD (read-only, zero-extended to 32).
REQ-017 SHALL map 0x100 CLEAR (write-only, reads 0): bit i set clears channel i counters, FIRST_WORD and FSM to IDLE on the cycle after the write handshake.
REQ-018 SHALL map 0x104 LED_SEL (R/W, bits [2:0], reset 0); values >= N_CH select channel 0.
REQ-019 SHALL give clear priority over a same-cycle accept; that beat is not counted and FSM returns IDLE.
REQ-020 SHALL drive led = FIRST_WORD[7:0] of selected channel, registered.
REQ-021 SHALL accept a write only when awvalid & wvalid both high; assert awready and wready together for one cycle; assert bvalid next cycle, hold until bready.
REQ-022 SHALL ignore wstrb except byte 0 for CLEAR and LED_SEL.
REQ-023 SHALL accept a read with arready one cycle, present rdata/rvalid next cycle, hold until rready; one outstanding read and one outstanding write.
REQ-024 SHALL return rdata 0 and OKAY for unmapped reads, OKAY and no effect for unmapped writes; bresp/rresp always 2'b00.
REQ-025 SHALL serve reads and writes independently; a register read in the cycle a counter updates returns the pre-update value.

Reset
REQ-026 SHALL on rst set all counters, FIRST_WORD, LED_SEL, led to 0 and all FSMs to IDLE.
REQ-027 SHALL on rst deassert awready, wready, bvalid, arready, rvalid and abandon any in-flight AXI-lite transaction.
REQ-028 SHALL, after rst is released mid-frame, treat the next accepted beat as a frame start.

Verification
REQ-029 Ch0: 3-beat frame, tkeep ff,ff,0f, first tdata 0x...A5, tlast on beat 3 -> FRAMES=1, BYTES=20, ERRORS=0, FIRST_WORD[7:0]=0xA5, led=0xA5.
REQ-030 Ch1: single-beat frame, tlast & tuser, tkeep 01 -> FRAMES=1, BYTES=1, ERRORS=1, FSM IDLE.
REQ-031 tvalid high, tready low for 5 cycles on ch2 -> all ch2 counters remain 0.
REQ-032 Preload FRAMES to 0xFFFFFFFE via 2 frames from forced state, or CNT_WIDTH=16 and 65537 frames -> FRAMES=0xFFFF, no wrap.
REQ-033 Write 0x1 to 0x100 in same cycle as ch0 tlast accept -> ch0 FRAMES=0; ch1 counters unchanged; bvalid one cycle after handshake.
REQ-034 Write LED_SEL=1, read 0x104 -> rdata=1, led shows ch1 FIRST_WORD[7:0]; read 0x200 -> rdata=0, rresp=00.
